// File: rtl/gemm_sched_pkg.sv
// Shared types and constants for the GEMM job scheduler.
package gemm_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_DONE,
        ST_ABORT
    } sched_state_t;

    // Owner-index width; never narrower than one bit
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gemm_sched_if.sv
// Scheduler-to-engine control bus: start/reset/operands out, busy/done back.
interface gemm_sched_if import gemm_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned SEL_W      = 2
);
    logic                  oeng_start;
    logic                  oeng_rst;
    logic [DATA_WIDTH-1:0] oeng_alpha;
    logic [DATA_WIDTH-1:0] oeng_beta;
    logic [SEL_W-1:0]      oeng_sel;
    logic                  ieng_busy;
    logic                  ieng_done;

    modport master (
        output oeng_start, oeng_rst, oeng_alpha, oeng_beta, oeng_sel,
        input  ieng_busy, ieng_done
    );

    modport slave (
        input  oeng_start, oeng_rst, oeng_alpha, oeng_beta, oeng_sel,
        output ieng_busy, ieng_done
    );
endinterface

// File: rtl/gemm_sched_rr_arbiter.sv
// Combinational masked-priority round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned SEL_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   gnt_idx,
    output logic               gnt_valid
);
    logic [NUM_REQ-1:0] w_masked;
    logic [SEL_W-1:0]   w_hi_idx;
    logic [SEL_W-1:0]   w_lo_idx;
    logic               w_hi_valid;

    always_comb begin
        w_masked   = '0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        w_hi_valid = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            w_masked[i] = req[i] && (i >= int'(ptr));
        end
        // Descending scan so the lowest set bit wins
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_hi_idx   = SEL_W'(i);
                w_hi_valid = 1'b1;
            end
            if (req[i]) begin
                w_lo_idx = SEL_W'(i);
            end
        end
        gnt_idx   = w_hi_valid ? w_hi_idx : w_lo_idx;
        gnt_valid = |req;
    end
endmodule

// File: rtl/gemm_sched.sv
// Shares one GEMM engine among NUM_REQ requesters with round-robin arbitration and a watchdog.
module gemm_sched import gemm_pkg::*; #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                                iclk,
    input  logic                                irst,
    input  logic [NUM_REQ-1:0]                  ireq,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  ialpha,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  ibeta,
    output logic [NUM_REQ-1:0]                  ogrant,
    output logic [NUM_REQ-1:0]                  odone,
    output logic [NUM_REQ-1:0]                  oerr,
    output logic                                obusy,
    gemm_sched_if.master                        eng
);
    localparam int unsigned SEL_W    = sel_width(NUM_REQ);
    localparam int unsigned CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    sched_state_t          r_state;
    logic [SEL_W-1:0]      r_rr_ptr;
    logic [SEL_W-1:0]      r_sel;
    logic [CNT_W-1:0]      r_cnt;
    logic [NUM_REQ-1:0]    r_grant;
    logic [NUM_REQ-1:0]    r_done;
    logic [NUM_REQ-1:0]    r_err;
    logic                  r_start;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_alpha;
    logic [DATA_WIDTH-1:0] r_beta;

    logic [SEL_W-1:0]      w_gnt_idx;
    logic                  w_gnt_valid;
    logic [NUM_REQ-1:0]    w_gnt_onehot;
    logic [NUM_REQ-1:0]    w_sel_onehot;
    logic [SEL_W-1:0]      w_next_ptr;
    logic                  w_unused_busy;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_arb (
        .req       (ireq),
        .ptr       (r_rr_ptr),
        .gnt_idx   (w_gnt_idx),
        .gnt_valid (w_gnt_valid)
    );

    assign w_gnt_onehot = NUM_REQ'(1) << w_gnt_idx;
    assign w_sel_onehot = NUM_REQ'(1) << r_sel;
    assign w_next_ptr   = (r_sel == SEL_W'(NUM_REQ - 1)) ? '0 : r_sel + 1'b1;
    // Engine busy is status only and never steers the scheduler
    assign w_unused_busy = eng.ieng_busy;

    always_ff @(posedge iclk) begin
        if (!irst) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_sel    <= '0;
            r_cnt    <= '0;
            r_grant  <= '0;
            r_done   <= '0;
            r_err    <= '0;
            r_start  <= 1'b0;
            r_busy   <= 1'b0;
            r_alpha  <= '0;
            r_beta   <= '0;
        end else begin
            r_start <= 1'b0;
            r_done  <= '0;
            r_err   <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_state <= ST_START;
                        r_sel   <= w_gnt_idx;
                        r_alpha <= ialpha[w_gnt_idx];
                        r_beta  <= ibeta[w_gnt_idx];
                        r_start <= 1'b1;
                        r_grant <= w_gnt_onehot;
                        r_busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    r_state <= ST_RUN;
                    r_cnt   <= '0;
                end
                ST_RUN: begin
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    // Done wins over a coincident watchdog expiry
                    if (eng.ieng_done) begin
                        r_state <= ST_DONE;
                        r_grant <= '0;
                        r_done  <= w_sel_onehot;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_ABORT;
                        r_grant <= '0;
                        r_err   <= w_sel_onehot;
                    end
                end
                ST_DONE, ST_ABORT: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_rr_ptr <= w_next_ptr;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ogrant         = r_grant;
    assign odone          = r_done;
    assign oerr           = r_err;
    assign obusy          = r_busy;
    assign eng.oeng_start = r_start;
    assign eng.oeng_alpha = r_alpha;
    assign eng.oeng_beta  = r_beta;
    assign eng.oeng_sel   = r_sel;
    // Engine resets alongside the scheduler, and for one cycle on abort
    assign eng.oeng_rst   = !irst || (r_state == ST_ABORT);

endmodule
